mux_cuentas_barrido: RTL and testbench

MUX_CUENTAS_BARRIDO -- requirements
Module: mux_cuentas_barrido

---
 rtl/mux_cuentas_barrido_pkg.sv | 17 +
 rtl/divisor_barrido.sv | 34 +++
 rtl/mux_cuentas_barrido.sv | 95 +++++++++
 tb/tb_mux_cuentas_barrido.sv | 215 +++++++++++++++++++++
 4 files changed

// File: rtl/mux_cuentas_barrido_pkg.sv
// Shared definitions for the channel scan multiplexer.
//   modo_e : operating mode encoding (manual selection / automatic scan)
//   clog2  : field width needed to index 'valor' items (never below 1)
package mux_cuentas_barrido_pkg;

  typedef enum logic {
    MODO_MANUAL  = 1'b0,
    MODO_BARRIDO = 1'b1
  } modo_e;

  function automatic int unsigned clog2(input int unsigned valor);
    int unsigned ancho = 0;
    while ((32'd1 << ancho) < valor) ancho++;
    return (ancho == 0) ? 1 : ancho;
  endfunction

endpackage

// File: rtl/divisor_barrido.sv
// Scan-step prescaler: counts 0..PRESCALA-1 while enabled and wraps.
//   clk       : clock, rising edge
//   reset_n   : synchronous active-low clear of the count
//   habilitar : 1 = count, 0 = hold the current count
//   tick      : high during the wrap cycle (count at PRESCALA-1 and enabled)
module divisor_barrido
  import mux_cuentas_barrido_pkg::*;
#(
  parameter int unsigned PRESCALA = 50000
) (
  input  logic clk,
  input  logic reset_n,
  input  logic habilitar,
  output logic tick
);

  localparam int unsigned CW = clog2(PRESCALA);
  localparam logic [CW-1:0] FIN = CW'(PRESCALA - 1);

  logic [CW-1:0] r_cnt;
  logic          w_fin;

  assign w_fin = (r_cnt == FIN);
  assign tick  = habilitar && w_fin;

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_cnt <= '0;
    end else if (habilitar) begin
      r_cnt <= w_fin ? '0 : r_cnt + CW'(1);
    end
  end

endmodule

// File: rtl/mux_cuentas_barrido.sv
// Channel multiplexer with manual selection or automatic timed scan.
//   clk, reset_n : clock and synchronous active-low reset
//   datos        : CANALES channels of ANCHO bits, channel k at [k*ANCHO +: ANCHO]
//   modo         : 0 manual (seleccion), 1 automatic scan every PRESCALA cycles
//   seleccion    : manual channel index (out-of-range values give Y=0)
//   congelar     : hold channel, prescaler and Y
//   Y            : registered data of the active channel (1-cycle latency)
//   canal_act    : active channel index
//   y_valido     : pulse on the first Y cycle from a new channel
module mux_cuentas_barrido
  import mux_cuentas_barrido_pkg::*;
#(
  parameter int unsigned ANCHO    = 4,
  parameter int unsigned CANALES  = 4,
  parameter int unsigned PRESCALA = 50000,
  parameter int unsigned SEL_W    = clog2(CANALES)
) (
  input  logic                       clk,
  input  logic                       reset_n,
  input  logic [CANALES*ANCHO-1:0]   datos,
  input  logic                       modo,
  input  logic [SEL_W-1:0]           seleccion,
  input  logic                       congelar,
  output logic [ANCHO-1:0]           Y,
  output logic [SEL_W-1:0]           canal_act,
  output logic                       y_valido
);

  logic [SEL_W-1:0] r_canal;
  logic [SEL_W-1:0] r_y_canal;
  logic [ANCHO-1:0] r_y;
  logic             r_valido;

  logic             w_barrido;
  logic             w_tick;
  logic             w_div_rst_n;
  logic [SEL_W-1:0] w_canal_sig;
  logic [ANCHO-1:0] w_dato;

  assign w_barrido = (modo == MODO_BARRIDO);

  // Manual mode keeps the prescaler cleared, unless frozen (freeze wins
  // over mode, so the held count must survive a mode change while frozen).
  assign w_div_rst_n = reset_n && (w_barrido || congelar);

  divisor_barrido #(
    .PRESCALA(PRESCALA)
  ) u_divisor (
    .clk      (clk),
    .reset_n  (w_div_rst_n),
    .habilitar(w_barrido && !congelar),
    .tick     (w_tick)
  );

  // Channel decode; an index with no matching channel yields zero.
  always_comb begin
    w_dato = '0;
    for (int unsigned k = 0; k < CANALES; k++) begin
      if (r_canal == SEL_W'(k)) w_dato = datos[k*ANCHO +: ANCHO];
    end
  end

  // The >= compare also sends an out-of-range manual index back to 0.
  always_comb begin
    w_canal_sig = r_canal;
    if (!w_barrido) begin
      w_canal_sig = seleccion;
    end else if (w_tick) begin
      w_canal_sig = (r_canal >= SEL_W'(CANALES - 1)) ? '0 : r_canal + SEL_W'(1);
    end
  end

  // r_y_canal remembers which channel Y currently shows; the pulse fires
  // when Y is loaded from a different one.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_canal   <= '0;
      r_y_canal <= '0;
      r_y       <= '0;
      r_valido  <= 1'b0;
    end else if (congelar) begin
      r_valido  <= 1'b0;
    end else begin
      r_canal   <= w_canal_sig;
      r_y       <= w_dato;
      r_y_canal <= r_canal;
      r_valido  <= (r_canal != r_y_canal);
    end
  end

  assign Y         = r_y;
  assign canal_act = r_canal;
  assign y_valido  = r_valido;

endmodule

// File: tb/tb_mux_cuentas_barrido.sv
module tb_mux_cuentas_barrido;

  typedef struct {
    logic        rst_n;
    logic        modo;
    logic [1:0]  sel;
    logic        cong;
    logic [15:0] datos;
    logic        chk_b;
    logic [3:0]  y;
    logic [1:0]  c;
    logic        v;
  } vec_t;

  typedef struct {
    logic       chk_b;
    logic [3:0] y;
    logic [1:0] c;
    logic       v;
    int         idx;
  } exp_t;

  logic        clk;
  logic        rst_n;
  logic        modo;
  logic [1:0]  sel;
  logic        cong;
  logic [15:0] datos;
  logic [3:0]  ya;
  logic [1:0]  ca;
  logic        va;
  logic [3:0]  yb;
  logic [1:0]  cb;
  logic        vb;

  int n_cmp = 0;
  int n_bad = 0;
  vec_t tbl[$];
  exp_t sbq[$];

  localparam logic [15:0] DA = 16'hDCBA;
  localparam logic [15:0] DM = 16'hD7BA;
  localparam logic [15:0] DB = 16'h0CBA;

  mux_cuentas_barrido #(
    .ANCHO(4), .CANALES(4), .PRESCALA(3)
  ) dut_a (
    .clk(clk), .reset_n(rst_n), .datos(datos), .modo(modo),
    .seleccion(sel), .congelar(cong), .Y(ya), .canal_act(ca), .y_valido(va)
  );

  mux_cuentas_barrido #(
    .ANCHO(4), .CANALES(3), .PRESCALA(3)
  ) dut_b (
    .clk(clk), .reset_n(rst_n), .datos(datos[11:0]), .modo(modo),
    .seleccion(sel), .congelar(cong), .Y(yb), .canal_act(cb), .y_valido(vb)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout required completion");
    $fatal(1, "timeout");
  end

  function automatic void add(input logic r, input logic m, input logic [1:0] s,
                              input logic cg, input logic [15:0] d, input logic b,
                              input logic [3:0] y, input logic [1:0] c, input logic v);
    vec_t t;
    t.rst_n = r; t.modo = m; t.sel = s; t.cong = cg; t.datos = d;
    t.chk_b = b; t.y = y; t.c = c; t.v = v;
    tbl.push_back(t);
  endfunction

  task automatic cmp(input string name, input int idx, input int act, input int req);
    n_cmp++;
    if (act != req) begin
      n_bad++;
      $display("FAIL %s step %0d: got %0h required %0h", name, idx, act, req);
    end
  endtask

  task automatic check();
    exp_t e;
    if (sbq.size() == 0) begin
      n_cmp++;
      n_bad++;
      $display("FAIL scoreboard: got empty queue required one entry");
      return;
    end
    e = sbq.pop_front();
    if (e.chk_b) begin
      cmp("b.Y", e.idx, int'(yb), int'(e.y));
      cmp("b.canal_act", e.idx, int'(cb), int'(e.c));
      cmp("b.y_valido", e.idx, int'(vb), int'(e.v));
    end else begin
      cmp("a.Y", e.idx, int'(ya), int'(e.y));
      cmp("a.canal_act", e.idx, int'(ca), int'(e.c));
      cmp("a.y_valido", e.idx, int'(va), int'(e.v));
    end
  endtask

  task automatic apply(input vec_t t, input int idx);
    exp_t e;
    @(negedge clk);
    rst_n = t.rst_n; modo = t.modo; sel = t.sel; cong = t.cong; datos = t.datos;
    e.chk_b = t.chk_b; e.y = t.y; e.c = t.c; e.v = t.v; e.idx = idx;
    sbq.push_back(e);
    @(posedge clk);
    #1;
    check();
  endtask

  initial begin
    vec_t f;
    int split;
    rst_n = 1'b0; modo = 1'b0; sel = '0; cong = 1'b0; datos = DA;

    // 3-channel instance: out-of-range manual index, then scan recovery and wrap 2->0
    add(0,1,0,0,DB,1, 4'h0,0,0);
    add(1,0,3,0,DB,1, 4'hA,3,0);
    add(1,0,3,0,DB,1, 4'h0,3,1);
    add(1,1,3,0,DB,1, 4'h0,3,0);
    add(1,1,3,0,DB,1, 4'h0,3,0);
    add(1,1,3,0,DB,1, 4'h0,0,0);
    add(1,1,3,0,DB,1, 4'hA,0,1);
    add(1,1,3,0,DB,1, 4'hA,0,0);
    add(1,1,3,0,DB,1, 4'hA,1,0);
    add(1,1,3,0,DB,1, 4'hB,1,1);
    add(1,1,3,0,DB,1, 4'hB,1,0);
    add(1,1,3,0,DB,1, 4'hB,2,0);
    add(1,1,3,0,DB,1, 4'hC,2,1);
    add(1,1,3,0,DB,1, 4'hC,2,0);
    add(1,1,3,0,DB,1, 4'hC,0,0);
    add(1,1,3,0,DB,1, 4'hA,0,1);

    // 4-channel instance: reset, full scan A..D..A
    add(0,1,0,0,DA,0, 4'h0,0,0);
    add(1,1,0,0,DA,0, 4'hA,0,0);
    add(1,1,0,0,DA,0, 4'hA,0,0);
    add(1,1,0,0,DA,0, 4'hA,1,0);
    add(1,1,0,0,DA,0, 4'hB,1,1);
    add(1,1,0,0,DA,0, 4'hB,1,0);
    add(1,1,0,0,DA,0, 4'hB,2,0);
    add(1,1,0,0,DA,0, 4'hC,2,1);
    add(1,1,0,0,DA,0, 4'hC,2,0);
    add(1,1,0,0,DA,0, 4'hC,3,0);
    add(1,1,0,0,DA,0, 4'hD,3,1);
    add(1,1,0,0,DA,0, 4'hD,3,0);
    add(1,1,0,0,DA,0, 4'hD,0,0);
    add(1,1,0,0,DA,0, 4'hA,0,1);
    add(1,1,0,0,DA,0, 4'hA,0,0);
    add(1,1,0,0,DA,0, 4'hA,1,0);
    add(1,1,0,0,DA,0, 4'hB,1,1);
    add(1,1,0,0,DA,0, 4'hB,1,0);
    add(1,1,0,0,DA,0, 4'hB,2,0);
    add(1,1,0,0,DA,0, 4'hC,2,1);
    add(1,1,0,0,DA,0, 4'hC,2,0);
    add(1,1,0,0,DA,0, 4'hC,3,0);
    add(1,1,0,0,DA,0, 4'hD,3,1);
    // reset on channel 3 while frozen, then a full-period restart
    add(0,1,0,1,DA,0, 4'h0,0,0);
    add(1,1,0,0,DA,0, 4'hA,0,0);
    add(1,1,0,0,DA,0, 4'hA,0,0);
    add(1,1,0,0,DA,0, 4'hA,1,0);
    add(1,1,0,0,DA,0, 4'hB,1,1);
    split = tbl.size();

    // after the freeze: tick two cycles later
    add(1,1,0,0,DA,0, 4'hB,1,0);
    add(1,1,0,0,DA,0, 4'hB,2,0);
    add(1,1,0,0,DA,0, 4'hC,2,1);
    // manual selection, data change on unchanged channel, manual->auto, auto->manual
    add(1,0,0,0,DA,0, 4'hC,0,0);
    add(1,0,2,0,DA,0, 4'hA,2,1);
    add(1,0,2,0,DA,0, 4'hC,2,1);
    add(1,0,2,0,DA,0, 4'hC,2,0);
    add(1,0,2,0,DM,0, 4'h7,2,0);
    add(1,0,2,0,DM,0, 4'h7,2,0);
    add(1,1,2,0,DM,0, 4'h7,2,0);
    add(1,1,2,0,DM,0, 4'h7,2,0);
    add(1,1,2,0,DM,0, 4'h7,3,0);
    add(1,1,2,0,DM,0, 4'hD,3,1);
    add(1,0,1,0,DM,0, 4'hD,1,0);
    add(1,0,1,0,DM,0, 4'hB,1,1);
    // freeze has priority over seleccion and modo
    add(1,1,3,1,DA,0, 4'hB,1,0);
    add(1,0,3,1,DA,0, 4'hB,1,0);
    add(1,0,1,0,DA,0, 4'hB,1,0);

    for (int i = 0; i < split; i++) apply(tbl[i], i);

    // 10-cycle freeze at prescaler count 1 on channel 1; datos changes must not reach Y
    for (int i = 0; i < 10; i++) begin
      f.rst_n = 1'b1; f.modo = 1'b1; f.sel = 2'd0; f.cong = 1'b1;
      f.datos = (i % 2 == 0) ? 16'h1111 : DA;
      f.chk_b = 1'b0; f.y = 4'hB; f.c = 2'd1; f.v = 1'b0;
      apply(f, 1000 + i);
    end

    for (int i = split; i < tbl.size(); i++) apply(tbl[i], i);

    if (sbq.size() != 0) begin
      n_cmp++;
      n_bad++;
      $display("FAIL scoreboard_drain: got %0d left required 0", sbq.size());
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
